// File: rtl/dm_access_unit.sv
// dm_access_unit: CPU-side load/store initiator for the word-organised data
// memory. One request at a time; byte/halfword stores use read-modify-write.
module dm_access_unit #(
  parameter int unsigned DM_WORDS = 3072,
  parameter int unsigned OP_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [31:0]     req_pc,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic [31:0]     dm_add,
  output logic [31:0]     dm_data,
  output logic            dm_memW,
  output logic            dm_memR,
  output logic [31:0]     dm_pc,
  input  logic [31:0]     dm_rdata
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DM_BYTES = XLEN'(DM_WORDS * 4);

  localparam logic [OP_W-1:0] OP_LW  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SH  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SB  = OP_W'(7);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   dm_add_q, dm_add_d;
  logic [XLEN-1:0]   dm_data_q, dm_data_d;
  logic              memw_q, memw_d;
  logic              memr_q, memr_d;
  logic [XLEN-1:0]   dm_pc_q, dm_pc_d;

  logic [7:0]        byte_c;
  logic [15:0]       half_c;
  logic [XLEN-1:0]   load_ext_c;
  logic [XLEN-1:0]   merge_c;
  logic              bad_req_c;

  // Select the addressed lane from the returned word and extend it
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_c = dm_rdata[7:0];
      2'd1:    byte_c = dm_rdata[15:8];
      2'd2:    byte_c = dm_rdata[23:16];
      default: byte_c = dm_rdata[31:24];
    endcase
    half_c = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LB:   load_ext_c = {{24{byte_c[7]}}, byte_c};
      OP_LBU:  load_ext_c = {24'h0, byte_c};
      OP_LH:   load_ext_c = {{16{half_c[15]}}, half_c};
      OP_LHU:  load_ext_c = {16'h0, half_c};
      default: load_ext_c = dm_rdata;
    endcase
  end

  // Replace the target byte/halfword lane of the old word with store data
  always_comb begin
    merge_c = dm_rdata;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0:    merge_c[7:0]   = wdata_q[7:0];
        2'd1:    merge_c[15:8]  = wdata_q[7:0];
        2'd2:    merge_c[23:16] = wdata_q[7:0];
        default: merge_c[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merge_c[31:16] = wdata_q;
    end else begin
      merge_c[15:0] = wdata_q;
    end
  end

  // Misaligned or out-of-range check on the incoming request
  always_comb begin
    bad_req_c = (req_addr >= DM_BYTES);
    if ((req_op == OP_LW || req_op == OP_SW) && req_addr[1:0] != 2'b00)
      bad_req_c = 1'b1;
    if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
      bad_req_c = 1'b1;
  end

  // Next-state and next-output logic; DM controls are loaded one cycle ahead
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    pc_d        = pc_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    dm_add_d    = '0;
    dm_data_d   = '0;
    memw_d      = 1'b0;
    memr_d      = 1'b0;
    dm_pc_d     = '0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          op_d        = req_op;
          addr_d      = req_addr;
          wdata_d     = req_wdata[15:0];
          pc_d        = req_pc;
          req_ready_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (bad_req_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            dm_add_d = {req_addr[31:2], 2'b00};
            dm_pc_d  = req_pc;
            if (req_op == OP_SW) begin
              memw_d    = 1'b1;
              dm_data_d = req_wdata;
            end else begin
              memr_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (op_q == OP_SH || op_q == OP_SB) begin
          state_d   = MERGE;
          memw_d    = 1'b1;
          dm_add_d  = {addr_q[31:2], 2'b00};
          dm_data_d = merge_c;
          dm_pc_d   = pc_q;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          if (op_q != OP_SW) rsp_rdata_d = load_ext_c;
        end
      end
      MERGE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_q        <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      dm_add_q    <= '0;
      dm_data_q   <= '0;
      memw_q      <= 1'b0;
      memr_q      <= 1'b0;
      dm_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pc_q        <= pc_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      dm_add_q    <= dm_add_d;
      dm_data_q   <= dm_data_d;
      memw_q      <= memw_d;
      memr_q      <= memr_d;
      dm_pc_q     <= dm_pc_d;
    end
  end

  // Reset must suppress a DM access in the very cycle it is asserted
  assign dm_memW   = memw_q & ~reset;
  assign dm_memR   = memr_q & ~reset;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dm_add    = dm_add_q;
  assign dm_data   = dm_data_q;
  assign dm_pc     = dm_pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit with a word-wide DM model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_add;
  logic [31:0] dm_data;
  logic        dm_memW;
  logic        dm_memR;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  dm_access_unit #(.DM_WORDS(3072), .OP_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_add(dm_add), .dm_data(dm_data), .dm_memW(dm_memW), .dm_memR(dm_memR),
    .dm_pc(dm_pc), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DM model: combinational read, write on the rising edge, bench preload port
  logic [31:0] dm_mem [0:3071];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = 12'h0;
  logic [31:0] pl_data = 32'h0;
  assign dm_rdata = (dm_add[31:2] < 30'd3072) ? dm_mem[dm_add[13:2]] : 32'h0;
  always @(posedge clk) begin
    if (pl_en) dm_mem[pl_idx] <= pl_data;
    else if (dm_memW) dm_mem[dm_add[13:2]] <= dm_data;
  end

  typedef struct { logic [31:0] rdata; logic err; int lat; } rsp_t;
  typedef struct { logic [31:0] add; logic [31:0] data; logic [31:0] pc; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [31:0] ref_mem [0:3071];
  int total = 0;
  int bad = 0;

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_idx = addr[13:2]; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[addr[13:2]] = data;
  endtask

  // Reference model: expected response, expected DM write, access counts
  task automatic push_exp(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc,
                          output int nr, output int nw);
    logic        err;
    logic [31:0] w, v;
    logic [7:0]  b;
    logic [15:0] h;
    rsp_t r;
    wr_t  wr;
    err = (addr >= 32'd12288);
    if ((op == 3'd0 || op == 3'd5) && addr[1:0] != 2'b00) err = 1'b1;
    if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && addr[0]) err = 1'b1;
    nr = 0; nw = 0; v = 32'h0; w = 32'h0;
    if (err) begin
      r.lat = 1;
    end else begin
      w = ref_mem[addr[13:2]];
      b = 8'(w >> (8 * int'(addr[1:0])));
      h = addr[1] ? w[31:16] : w[15:0];
      r.lat = 2;
      case (op)
        3'd0: begin v = w; nr = 1; end
        3'd1: begin v = {{16{h[15]}}, h}; nr = 1; end
        3'd2: begin v = {16'h0, h}; nr = 1; end
        3'd3: begin v = {{24{b[7]}}, b}; nr = 1; end
        3'd4: begin v = {24'h0, b}; nr = 1; end
        3'd5: begin w = wdata; nw = 1; end
        3'd6: begin
          if (addr[1]) w[31:16] = wdata[15:0]; else w[15:0] = wdata[15:0];
          nr = 1; nw = 1; r.lat = 3;
        end
        default: begin
          w[8*int'(addr[1:0]) +: 8] = wdata[7:0];
          nr = 1; nw = 1; r.lat = 3;
        end
      endcase
      if (nw == 1) begin
        wr.add = {addr[31:2], 2'b00}; wr.data = w; wr.pc = pc;
        wr_q.push_back(wr);
        ref_mem[addr[13:2]] = w;
      end
    end
    r.rdata = v; r.err = err;
    rsp_q.push_back(r);
  endtask

  // Watch DUT from the cycle after accept until rsp_valid; pop and compare
  task automatic wait_rsp(input string nm, input int acc, input int nr, input int nw);
    int   reads = 0;
    int   writes = 0;
    bit   got = 0;
    rsp_t r;
    wr_t  wr;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      total++;
      if (dm_memR && dm_memW) begin bad++; $display("FAIL %s both_enables memR=%b memW=%b", nm, dm_memR, dm_memW); end
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL %s busy_ready got=%b want=0", nm, req_ready); end
      if (dm_memR) reads++;
      if (dm_memW) begin
        writes++;
        total++;
        if (wr_q.size() == 0) begin
          bad++; $display("FAIL %s unexpected_write add=%h data=%h", nm, dm_add, dm_data);
        end else begin
          wr = wr_q.pop_front();
          if (dm_add !== wr.add || dm_data !== wr.data || dm_pc !== wr.pc) begin
            bad++;
            $display("FAIL %s write got add=%h data=%h pc=%h want add=%h data=%h pc=%h",
                     nm, dm_add, dm_data, dm_pc, wr.add, wr.data, wr.pc);
          end
        end
      end
      if (dm_memR) begin
        total++;
        if (dm_add !== {req_addr_cap[31:2], 2'b00}) begin
          bad++; $display("FAIL %s read_add got=%h want=%h", nm, dm_add, {req_addr_cap[31:2], 2'b00});
        end
      end
      if (rsp_valid) begin
        got = 1;
        r = rsp_q.pop_front();
        total++;
        if (rsp_rdata !== r.rdata || rsp_err !== r.err || (cyc - acc) != r.lat) begin
          bad++;
          $display("FAIL %s rsp got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=%0d",
                   nm, rsp_rdata, rsp_err, cyc - acc, r.rdata, r.err, r.lat);
        end
      end
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout no rsp_valid", nm);
      rsp_q.delete(); wr_q.delete();
    end
    total++;
    if (reads != nr || writes != nw) begin
      bad++; $display("FAIL %s access_count got r=%0d w=%0d want r=%0d w=%0d", nm, reads, writes, nr, nw);
    end
  endtask

  logic [31:0] req_addr_cap = 32'h0;

  task automatic drive(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    req_addr_cap = addr;
  endtask

  task automatic wait_accept(input string nm, output int acc);
    acc = -1;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      @(negedge clk);
      if (req_ready) acc = cyc;
    end
    total++;
    if (acc < 0) begin bad++; $display("FAIL %s accept_timeout", nm); end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL %s after_rsp got valid=%b ready=%b want valid=0 ready=1", nm, rsp_valid, req_ready);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc);
    int nr, nw, acc;
    push_exp(op, addr, wdata, pc, nr, nw);
    @(posedge clk); #1;
    drive(op, addr, wdata, pc);
    wait_accept(nm, acc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (acc < 0) begin rsp_q.delete(); wr_q.delete(); return; end
    wait_rsp(nm, acc, nr, nw);
    idle_check(nm);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        dm_add !== 32'h0 || dm_data !== 32'h0 || dm_memW !== 1'b0 || dm_memR !== 1'b0 || dm_pc !== 32'h0) begin
      bad++; $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b add=%h data=%h w=%b r=%b pc=%h",
                      req_ready, rsp_valid, rsp_rdata, rsp_err, dm_add, dm_data, dm_memW, dm_memR, dm_pc);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_check("reset_release");
  endtask

  task automatic test_store_load();
    issue("sw_10", 3'd5, 32'h10, 32'hDEADBEEF, 32'h1000);
    issue("lw_10", 3'd0, 32'h10, 32'h0, 32'h1004);
  endtask

  task automatic test_byte_rmw();
    preload(32'h10, 32'h11223344);
    issue("sb_12", 3'd7, 32'h12, 32'h000000AB, 32'h1008);
    issue("lb_12", 3'd3, 32'h12, 32'h0, 32'h100C);
    issue("lbu_12", 3'd4, 32'h12, 32'h0, 32'h1010);
  endtask

  task automatic test_half_rmw();
    preload(32'h20, 32'h00000000);
    issue("sh_22", 3'd6, 32'h22, 32'h00008001, 32'h1014);
    issue("lh_22", 3'd1, 32'h22, 32'h0, 32'h1018);
    issue("lhu_22", 3'd2, 32'h22, 32'h0, 32'h101C);
  endtask

  task automatic test_errors();
    issue("lw_mis", 3'd0, 32'h13, 32'h0, 32'h1020);
    issue("sh_mis", 3'd6, 32'h21, 32'h1234, 32'h1024);
    issue("sw_oor", 3'd5, 32'h3000, 32'h55AA55AA, 32'h1028);
    issue("lb_oor", 3'd3, 32'h3001, 32'h0, 32'h102C);
  endtask

  task automatic test_reset_mid_rmw();
    int acc;
    preload(32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(3'd7, 32'h31, 32'h55, 32'h2000);
    wait_accept("rst_rmw", acc);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dm_memR !== 1'b1) begin bad++; $display("FAIL rst_rmw read_phase memR got=%b want=1", dm_memR); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (dm_memW !== 1'b0 || dm_memR !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_rmw reset_cycle memW=%b memR=%b valid=%b want 0 0 0", dm_memW, dm_memR, rsp_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        dm_add !== 32'h0 || dm_data !== 32'h0 || dm_memW !== 1'b0 || dm_memR !== 1'b0 || dm_pc !== 32'h0) begin
      bad++; $display("FAIL rst_rmw post_reset ready=%b valid=%b add=%h data=%h w=%b r=%b pc=%h",
                      req_ready, rsp_valid, dm_add, dm_data, dm_memW, dm_memR, dm_pc);
    end
    idle_check("rst_rmw_quiet");
    issue("rst_rmw_lw", 3'd0, 32'h30, 32'h0, 32'h2004);
  endtask

  task automatic test_back_to_back();
    int nr1, nw1, nr2, nw2, acc1, acc2;
    push_exp(3'd0, 32'h10, 32'h0, 32'h3000, nr1, nw1);
    push_exp(3'd5, 32'h40, 32'h0BADF00D, 32'h3004, nr2, nw2);
    @(posedge clk); #1;
    drive(3'd0, 32'h10, 32'h0, 32'h3000);
    wait_accept("b2b_lw", acc1);
    @(posedge clk); #1;
    drive(3'd5, 32'h40, 32'h0BADF00D, 32'h3004);
    req_addr_cap = 32'h10;
    wait_rsp("b2b_lw", acc1, nr1, nw1);
    req_addr_cap = 32'h40;
    @(negedge clk);
    acc2 = cyc;
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_second_accept ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp("b2b_sw", acc2, nr2, nw2);
    idle_check("b2b_sw");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++) preload(32'h100 + 32'(4 * i), $urandom);
    for (int i = 0; i < 24; i++) begin
      a = 32'h100 + 32'($urandom_range(0, 63));
      issue("rand", 3'($urandom_range(0, 7)), a, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_rmw();
    test_half_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    total++;
    if (rsp_q.size() != 0 || wr_q.size() != 0) begin
      bad++; $display("FAIL leftover_expect rsp=%0d wr=%0d want 0 0", rsp_q.size(), wr_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
- CPU-side initiator for the word-organised data memory (DM).
- Takes one load/store request at a time from the MEM stage and drives the DM word port (add, data, memW, memR, pc).
- Extracts and extends load bytes/halfwords from the returned word.
- Performs read-modify-write for byte and halfword stores, since DM only writes whole words.

Parameters:
- DM_WORDS, 3072, DM depth in words; byte addresses >= DM_WORDS*4 are out of range.
- OP_W, 3, width of the operation code.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_op  input  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
- req_addr  input  32  byte address
- req_wdata  input  32  store data; SH uses [15:0], SB uses [7:0]
- req_pc  input  32  PC of the issuing instruction
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  extended load result; 0 for stores and errors
- rsp_err  output  1  misaligned or out-of-range access; valid with rsp_valid
- dm_add  output  32  word address to DM, {addr[31:2],2'b00}
- dm_data  output  32  write word to DM
- dm_memW  output  1  DM write enable
- dm_memR  output  1  DM read enable
- dm_pc  output  32  captured PC forwarded to DM for write logging
- dm_rdata  input  32  DM combinational read word (DM output WB)

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous, active-high, sampled on the clk rising edge.
  - Reset state: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, dm_add=0, dm_data=0, dm_memW=0, dm_memR=0, dm_pc=0.
- State machine states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture op, addr, wdata and pc.
  - If misaligned or out of range, go to RESP with err=1. Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - Otherwise go to ACCESS.
  - req_ready=0 in every other state; requests there are ignored.
- ACCESS:
  - dm_add = captured word address; dm_pc = captured pc.
  - Loads: dm_memR=1; the extracted result is registered at the edge; next state RESP.
  - SW: dm_memW=1, dm_data=wdata, so DM writes at this edge; next state RESP.
  - SH/SB: dm_memR=1; dm_rdata is registered as the old word; next state MERGE.
- MERGE:
  - dm_memW=1.
  - dm_data = old word with the target lane replaced.
  - SB lane n=addr[1:0] occupies bits [8n+7:8n]; SH lane addr[1] selects [15:0] or [31:16].
  - Next state RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_rdata and rsp_err are held.
  - Next state IDLE. A new request can be accepted on the following cycle.
- Load extraction (little-endian lanes):
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Outputs:
  - dm_memR and dm_memW are never both 1.
  - Both are 0 in IDLE and RESP.
  - Both are forced to 0 whenever reset=1, including mid-operation.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - error: 1 cycle
  - LW/LH/LHU/LB/LBU/SW: 2 cycles
  - SH/SB: 3 cycles
- Reset mid-operation:
  - Return to IDLE with no DM write issued in the reset cycle.
  - A pending SB/SH is dropped after its read; no partial write occurs.
  - rsp_valid is not asserted for the aborted request.
- The unit handles one outstanding request only; there is no queueing.

Test Plan:
- Aligned store then load: SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> one dm_memW cycle with dm_add=0x10, dm_data=0xDEADBEEF; load rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid arrives 2 cycles after accept.
- Byte store RMW: word 0x10 holds 0x11223344; SB addr=0x12 wdata=0xAB -> read cycle, then write cycle with dm_data=0x11AB3344; rsp_valid 3 cycles after accept; a following LB 0x12 returns 0xFFFFFFAB and LBU 0x12 returns 0x000000AB.
- Halfword store RMW: word 0x20 holds 0x00000000; SH addr=0x22 wdata=0x8001 -> dm_data=0x80010000; LH 0x22 returns 0xFFFF8001 and LHU 0x22 returns 0x00008001.
- Misaligned and out of range: LW 0x13, SH 0x21, and SW 0x3000 (with DM_WORDS=3072) -> each gives rsp_err=1 one cycle after accept, rsp_rdata=0, and no dm_memR/dm_memW pulse.
- Reset mid-RMW: SB issued, reset asserted during the MERGE cycle -> dm_memW=0 in that cycle, no rsp_valid, state IDLE with req_ready=1 on the next cycle, all outputs 0.
- Back-to-back requests: req_valid held high with LW, then SW queued -> the second request is accepted only on the cycle after rsp_valid, with req_ready=0 during ACCESS, MERGE and RESP.
